sram_like_axi_bridge: RTL and testbench
=======================================

# sram_like_axi_bridge

Bridges the two SRAM-like master ports of the CPU core, instruction and data, onto a single AXI3 master interface. The data port is driven by the data-side SRAM-to-SRAM-like converter. The bridge arbitrates between the two ports, issues one single-beat AXI transaction at a time, and returns `addr_ok`/`data_ok` handshakes to the requesting port. It sits between the core's SRAM-like converters and the SoC AXI crossbar.

## Interface
- No parameters; ID width fixed at 4, data width fixed at 32.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- inst_req, inst_wr  in  1 each  instruction-port request, write flag.
- inst_size  in  2  0 = byte, 1 = half, 2 = word.
- inst_addr, inst_wdata  in  32 each  address, write data.
- inst_rdata  out  32  read data; valid only while inst_data_ok = 1.
- inst_addr_ok, inst_data_ok  out  1 each  address accepted, transaction done.
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok: same as the inst_* signals, for the data port.
- arid 4 / araddr 32 / arsize 3 / arvalid 1  out; arready  in 1.
- arlen 8, arburst 2, arlock 2, arcache 4, arprot 3  out, constants 0, 1, 0, 0, 0.
- rid 4, rdata 32, rresp 2, rlast 1, rvalid 1  in; rready  out 1.
- awid 4 / awaddr 32 / awsize 3 / awvalid 1  out; awready  in 1.
- awlen, awburst, awlock, awcache, awprot  out, same constants as the ar* fields.
- wid 4 / wdata 32 / wstrb 4 / wlast 1 / wvalid 1  out; wready  in 1.
- bid 4, bresp 2, bvalid 1  in; bready  out 1.

## Operation
- FSM states: IDLE, AR, R, W, B.
- IDLE
  - Grant goes to data_req if it is asserted, else to inst_req. Data has fixed priority.
  - The granted port's `addr_ok` = 1 combinationally in the same cycle. The other port's `addr_ok` = 0.
  - On grant, latch addr, size, wdata, wr and source (0 = inst, 1 = data).
  - Next state is AR if wr = 0, else W.
- AR
  - arvalid = 1 with the latched fields. arid = source (0 or 1). arsize = {0, size}.
  - On arready, go to R.
- R
  - rready = 1.
  - On rvalid, the source port gets `data_ok` = 1 and its `rdata` = AXI rdata (combinational pass-through). Then go to IDLE.
  - rresp and rid are ignored; only one transaction is ever outstanding.
- W
  - awvalid and wvalid are raised together; wlast = 1; wid = awid = source.
  - Sticky flags aw_done and w_done record each handshake. Each valid drops once its own handshake completes. The state waits until both flags are set, in either order or in the same cycle.
  - Next state is B.
- B
  - bready = 1.
  - On bvalid, go to IDLE; the `data_ok` timing is set by the configuration macro below.
- wstrb
  - size 0: 4'b0001 << addr[1:0].
  - size 1: addr[1] ? 4'b1100 : 4'b0011.
  - size 2 or 3: 4'b1111.
- Addresses are forwarded unmodified. wdata is forwarded unshifted; the core has already placed byte lanes.
- A request arriving while the FSM is not in IDLE gets `addr_ok` = 0 and must be held by its master.

## Timing
- Reset values: all *valid, rready, bready, addr_ok, data_ok = 0; rdata outputs = 0 when not in R; FSM = IDLE; latches and flags cleared.
- Reset mid-transaction: the FSM returns to IDLE and all valids drop on the next edge, with no completion pulse. The AXI slave is reset by the same rst.
- Minimum read latency: req/addr_ok in cycle 0, arvalid in cycle 1, data_ok in cycle 2 (arready in cycle 1 and rvalid in cycle 2).
- Minimum write latency is also 2 cycles, with all handshakes zero-wait.
- `data_ok` is exactly a one-cycle pulse per accepted request.
- A new request can be granted in the cycle after `data_ok`.
- Simultaneous inst_req and data_req: data is granted; inst is granted at the next IDLE if it is still asserted.
- All AXI valid signals, once raised, are held until their handshake completes (AXI rule).

## Configuration
- WRITE_EARLY_ACK_EN
  - Defined: the write `data_ok` pulses in the cycle the W state completes (both handshakes done). B is still awaited before returning to IDLE, and no `data_ok` is given at B.
  - Undefined (default): the write `data_ok` pulses in the B state on bvalid.

## Structure
- Package bridge_pkg holds:
  - the state enum {IDLE, AR, R, W, B};
  - ID constants INST_ID = 4'd0 and DATA_ID = 4'd1;
  - the AXI constant field values (len, burst, lock, cache, prot);
  - the size encodings.
- Sub-module sram_like_wstrb_gen: combinational (size, addr[1:0]) -> wstrb.

## Test plan
- Lone data read of 0x1FC0_0004, arready and rvalid immediate, rdata 0xDEADBEEF:
  - data_addr_ok in cycle 0; arid = 1, arsize = 2 in cycle 1; data_data_ok with data_rdata 0xDEADBEEF in cycle 2; inst_* silent.
- inst_req and data_req both asserted in the same cycle:
  - data granted first (arid 1); inst granted at the next IDLE (arid 0); exactly one data_ok per port.
- Byte write size 0, addr 0x...3:
  - wstrb = 4'b1000, awsize = 0, wlast = 1.
- Half write at addr 0x...2:
  - wstrb = 4'b1100.
- Write with awready delayed 3 cycles and wready immediate:
  - wvalid drops after 1 cycle; awvalid is held 4 cycles; B is entered only after both handshakes.
  - data_ok on bvalid; with WRITE_EARLY_ACK_EN defined, data_ok instead follows the awready cycle.
- rst asserted while in R with rvalid low:
  - next cycle: FSM IDLE, rready = 0, no data_ok; a fresh read then completes normally.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and constants for the SRAM-like to AXI3 bridge.
package bridge_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    W    = 3'd3,
    B    = 3'd4
  } state_t;

  localparam logic [3:0] INST_ID   = 4'd0;
  localparam logic [3:0] DATA_ID   = 4'd1;

  localparam logic [7:0] AXI_LEN   = 8'd0;
  localparam logic [1:0] AXI_BURST = 2'd1;
  localparam logic [1:0] AXI_LOCK  = 2'd0;
  localparam logic [3:0] AXI_CACHE = 4'd0;
  localparam logic [2:0] AXI_PROT  = 3'd0;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_like_wstrb_gen.sv
// Byte-lane strobe for a single write beat from transfer size and low address bits.
module sram_like_wstrb_gen
  import bridge_pkg::*;
(
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_wstrb
);

  always_comb begin
    o_wstrb = 4'b1111;
    case (i_size)
      SIZE_BYTE: o_wstrb = 4'b0001 << i_addr_lo;
      SIZE_HALF: o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   o_wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_like_axi_bridge.sv
// Arbitrates the inst/data SRAM-like ports onto one AXI3 master, one beat at a time.
// Define WRITE_EARLY_ACK_EN to acknowledge writes when W completes instead of on bvalid.
module sram_like_axi_bridge
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_wr;
  logic        r_src;
  logic        r_aw_done;
  logic        r_w_done;

  logic        w_grant;
  logic        w_aw_all;
  logic        w_w_all;
  logic        w_wr_done;
  logic        w_rd_ok;
  logic        w_wr_ok;
  logic        w_ok;
  logic [3:0]  w_id;
  logic [3:0]  w_wstrb;
  logic        w_unused_ok;

  // Single outstanding transaction, so response IDs and status carry no information.
  assign w_unused_ok = &{1'b0, rid, rresp, rlast, bid, bresp, r_wr};

  assign w_grant   = (r_state == IDLE) && (inst_req || data_req) && !rst;
  assign w_aw_all  = r_aw_done || (awvalid && awready);
  assign w_w_all   = r_w_done || (wvalid && wready);
  assign w_wr_done = (r_state == W) && w_aw_all && w_w_all;
  assign w_rd_ok   = (r_state == R) && rvalid && !rst;
`ifdef WRITE_EARLY_ACK_EN
  assign w_wr_ok   = w_wr_done && !rst;
`else
  assign w_wr_ok   = (r_state == B) && bvalid && !rst;
`endif
  assign w_ok      = w_rd_ok || w_wr_ok;
  assign w_id      = r_src ? DATA_ID : INST_ID;

  assign data_addr_ok = w_grant && data_req;
  assign inst_addr_ok = w_grant && !data_req;
  assign data_data_ok = w_ok && r_src;
  assign inst_data_ok = w_ok && !r_src;
  assign data_rdata   = ((r_state == R) && r_src)  ? rdata : 32'd0;
  assign inst_rdata   = ((r_state == R) && !r_src) ? rdata : 32'd0;

  assign arid    = w_id;
  assign araddr  = r_addr;
  assign arsize  = {1'b0, r_size};
  assign arlen   = AXI_LEN;
  assign arburst = AXI_BURST;
  assign arlock  = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;
  assign arvalid = (r_state == AR);
  assign rready  = (r_state == R);

  assign awid    = w_id;
  assign awaddr  = r_addr;
  assign awsize  = {1'b0, r_size};
  assign awlen   = AXI_LEN;
  assign awburst = AXI_BURST;
  assign awlock  = AXI_LOCK;
  assign awcache = AXI_CACHE;
  assign awprot  = AXI_PROT;
  assign awvalid = (r_state == W) && !r_aw_done;

  assign wid     = w_id;
  assign wdata   = r_wdata;
  assign wstrb   = w_wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = (r_state == W) && !r_w_done;
  assign bready  = (r_state == B);

  sram_like_wstrb_gen u_wstrb (
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .o_wstrb   (w_wstrb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_size    <= 2'd0;
      r_wr      <= 1'b0;
      r_src     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (inst_req || data_req) begin
            r_src     <= data_req;
            r_addr    <= data_req ? data_addr  : inst_addr;
            r_wdata   <= data_req ? data_wdata : inst_wdata;
            r_size    <= data_req ? data_size  : inst_size;
            r_wr      <= data_req ? data_wr    : inst_wr;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= (data_req ? data_wr : inst_wr) ? W : AR;
          end
        end
        AR: if (arready) r_state <= R;
        R:  if (rvalid)  r_state <= IDLE;
        W: begin
          // Either channel may finish first; the finished one stops driving valid.
          if (w_wr_done) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= B;
          end else begin
            r_aw_done <= w_aw_all;
            r_w_done  <= w_w_all;
          end
        end
        B:  if (bvalid)  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Directed self-checking bench for sram_like_axi_bridge with a hand-driven AXI slave.
module tb_sram_like_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int checks = 0;
  int errors = 0;
  int cnt_inst_ok = 0;
  int cnt_data_ok = 0;

  always #5 clk = ~clk;

  sram_like_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Completion pulses are tallied independently to catch extra or missing acks.
  always @(negedge clk) begin
    if (inst_data_ok === 1'b1) cnt_inst_ok <= cnt_inst_ok + 1;
    if (data_data_ok === 1'b1) cnt_data_ok <= cnt_data_ok + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and outputs sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    tick(); tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("rst_rdata", data_rdata, 0);
    chk("const_arburst", arburst, 1);
    chk("const_awlen", awlen, 0);

    // Lone data read
    tick();
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h1FC0_0004; arready = 1;
    settle();
    chk("rd_c0_data_addr_ok", data_addr_ok, 1);
    chk("rd_c0_inst_addr_ok", inst_addr_ok, 0);
    tick();
    data_req = 0;
    settle();
    chk("rd_c1_arvalid", arvalid, 1);
    chk("rd_c1_arid", arid, 1);
    chk("rd_c1_arsize", arsize, 2);
    chk("rd_c1_araddr", araddr, 32'h1FC0_0004);
    chk("rd_c1_data_ok", data_data_ok, 0);
    tick();
    rvalid = 1; rdata = 32'hDEAD_BEEF;
    settle();
    chk("rd_c2_rready", rready, 1);
    chk("rd_c2_data_ok", data_data_ok, 1);
    chk("rd_c2_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("rd_c2_inst_ok", inst_data_ok, 0);
    chk("rd_c2_inst_rdata", inst_rdata, 0);
    tick();
    rvalid = 0;
    settle();
    chk("rd_c3_data_ok", data_data_ok, 0);
    chk("rd_c3_rready", rready, 0);

    // Simultaneous requests: data wins, inst follows
    inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'h0000_0100;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_0200;
    settle();
    chk("arb_c0_data_addr_ok", data_addr_ok, 1);
    chk("arb_c0_inst_addr_ok", inst_addr_ok, 0);
    tick();
    data_req = 0;
    settle();
    chk("arb_c1_arid", arid, 1);
    chk("arb_c1_araddr", araddr, 32'h0000_0200);
    chk("arb_c1_inst_addr_ok", inst_addr_ok, 0);
    tick();
    rvalid = 1; rdata = 32'h1111_1111;
    settle();
    chk("arb_c2_data_ok", data_data_ok, 1);
    chk("arb_c2_inst_ok", inst_data_ok, 0);
    tick();
    rvalid = 0;
    settle();
    chk("arb_c3_inst_addr_ok", inst_addr_ok, 1);
    chk("arb_c3_data_ok", data_data_ok, 0);
    tick();
    inst_req = 0;
    settle();
    chk("arb_c4_arid", arid, 0);
    chk("arb_c4_araddr", araddr, 32'h0000_0100);
    tick();
    rvalid = 1; rdata = 32'h2222_2222;
    settle();
    chk("arb_c5_inst_ok", inst_data_ok, 1);
    chk("arb_c5_inst_rdata", inst_rdata, 32'h2222_2222);
    chk("arb_c5_data_ok", data_data_ok, 0);
    tick();
    rvalid = 0; arready = 0;
    settle();
    chk("arb_c6_inst_ok", inst_data_ok, 0);

    // Byte write to lane 3
    awready = 1; wready = 1;
    data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h8000_0003; data_wdata = 32'hAB00_0000;
    settle();
    chk("wb_c0_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 0; data_wr = 0;
    settle();
    chk("wb_c1_awvalid", awvalid, 1);
    chk("wb_c1_wvalid", wvalid, 1);
    chk("wb_c1_wstrb", wstrb, 4'b1000);
    chk("wb_c1_awsize", awsize, 0);
    chk("wb_c1_wlast", wlast, 1);
    chk("wb_c1_wid", wid, 1);
    chk("wb_c1_wdata", wdata, 32'hAB00_0000);
`ifdef WRITE_EARLY_ACK_EN
    chk("wb_c1_data_ok", data_data_ok, 1);
`else
    chk("wb_c1_data_ok", data_data_ok, 0);
`endif
    tick();
    bvalid = 1;
    settle();
    chk("wb_c2_bready", bready, 1);
    chk("wb_c2_awvalid", awvalid, 0);
`ifdef WRITE_EARLY_ACK_EN
    chk("wb_c2_data_ok", data_data_ok, 0);
`else
    chk("wb_c2_data_ok", data_data_ok, 1);
`endif
    tick();
    bvalid = 0;
    settle();
    chk("wb_c3_data_ok", data_data_ok, 0);
    chk("wb_c3_bready", bready, 0);

    // Half write to upper half via the inst port
    inst_req = 1; inst_wr = 1; inst_size = 1; inst_addr = 32'h4000_0002; inst_wdata = 32'h5A5A_0000;
    settle();
    chk("wh_c0_inst_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req = 0; inst_wr = 0;
    settle();
    chk("wh_c1_wstrb", wstrb, 4'b1100);
    chk("wh_c1_awsize", awsize, 1);
    chk("wh_c1_awid", awid, 0);
    chk("wh_c1_awaddr", awaddr, 32'h4000_0002);
    tick();
    bvalid = 1;
    settle();
`ifdef WRITE_EARLY_ACK_EN
    chk("wh_c2_inst_ok", inst_data_ok, 0);
`else
    chk("wh_c2_inst_ok", inst_data_ok, 1);
`endif
    tick();
    bvalid = 0;

    // Word write with awready late by three cycles
    awready = 0; wready = 1;
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h0000_0010; data_wdata = 32'h0123_4567;
    settle();
    chk("wd_c0_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 0; data_wr = 0;
    settle();
    chk("wd_c1_awvalid", awvalid, 1);
    chk("wd_c1_wvalid", wvalid, 1);
    chk("wd_c1_wstrb", wstrb, 4'b1111);
    tick();
    settle();
    chk("wd_c2_wvalid", wvalid, 0);
    chk("wd_c2_awvalid", awvalid, 1);
    chk("wd_c2_bready", bready, 0);
    tick();
    settle();
    chk("wd_c3_awvalid", awvalid, 1);
    chk("wd_c3_bready", bready, 0);
    tick();
    awready = 1;
    settle();
    chk("wd_c4_awvalid", awvalid, 1);
    chk("wd_c4_wvalid", wvalid, 0);
`ifdef WRITE_EARLY_ACK_EN
    chk("wd_c4_data_ok", data_data_ok, 1);
`else
    chk("wd_c4_data_ok", data_data_ok, 0);
`endif
    tick();
    awready = 0;
    settle();
    chk("wd_c5_bready", bready, 1);
    chk("wd_c5_awvalid", awvalid, 0);
    chk("wd_c5_data_ok", data_data_ok, 0);
    tick();
    bvalid = 1;
    settle();
`ifdef WRITE_EARLY_ACK_EN
    chk("wd_c6_data_ok", data_data_ok, 0);
`else
    chk("wd_c6_data_ok", data_data_ok, 1);
`endif
    tick();
    bvalid = 0;
    settle();
    chk("wd_c7_bready", bready, 0);

    // Reset while waiting in R
    arready = 1;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_0020;
    settle();
    chk("rr_c0_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 0;
    tick();
    settle();
    chk("rr_c2_rready", rready, 1);
    rst = 1;
    tick();
    rst = 0;
    settle();
    chk("rr_c3_rready", rready, 0);
    chk("rr_c3_arvalid", arvalid, 0);
    chk("rr_c3_data_ok", data_data_ok, 0);
    data_req = 1; data_addr = 32'h0000_0024;
    settle();
    chk("rr_c3_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 0;
    settle();
    chk("rr_c4_araddr", araddr, 32'h0000_0024);
    chk("rr_c4_arvalid", arvalid, 1);
    tick();
    rvalid = 1; rdata = 32'hCAFE_F00D;
    settle();
    chk("rr_c5_data_ok", data_data_ok, 1);
    chk("rr_c5_rdata", data_rdata, 32'hCAFE_F00D);
    tick();
    rvalid = 0; arready = 0;
    tick();
    tick();

    chk("total_data_ok", cnt_data_ok, 5);
    chk("total_inst_ok", cnt_inst_ok, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
